// File: rtl/astro_pkg.sv
// astro_pkg -- constants shared by the Astro game blocks.
//   Button bit indices, jogada event codes and the priority helper used by
//   controle_jogada, plus the constants used by astro_genius.
package astro_pkg;

   // Bit positions inside botoes / jogada / db_botoes
   localparam int BIT_CIMA     = 5;
   localparam int BIT_BAIXO    = 4;
   localparam int BIT_DIREITA  = 3;
   localparam int BIT_ESQUERDA = 2;
   localparam int BIT_TIRO     = 1;
   localparam int BIT_ESPECIAL = 0;

   // 3-bit event codes stored in the jogada FIFO
   localparam logic [2:0] COD_CIMA     = 3'd5;
   localparam logic [2:0] COD_BAIXO    = 3'd4;
   localparam logic [2:0] COD_DIREITA  = 3'd3;
   localparam logic [2:0] COD_ESQUERDA = 3'd2;
   localparam logic [2:0] COD_TIRO     = 3'd1;
   localparam logic [2:0] COD_ESPECIAL = 3'd0;

   // Buttons that auto-repeat while held (movement only)
   localparam logic [5:0] MASCARA_REPETE = 6'b111100;

   // astro_genius constants
   localparam int GENIUS_NUM_CORES    = 4;
   localparam int GENIUS_MAX_RODADAS  = 32;

   // Highest-priority event of a cycle:
   // especial > tiro > cima > baixo > direita > esquerda.
   // Caller guarantees at least one bit is set.
   function automatic logic [2:0] prioridade(input logic [5:0] ev);
      logic [2:0] c;
      c = COD_ESQUERDA;
      if (ev[BIT_ESPECIAL])      c = COD_ESPECIAL;
      else if (ev[BIT_TIRO])     c = COD_TIRO;
      else if (ev[BIT_CIMA])     c = COD_CIMA;
      else if (ev[BIT_BAIXO])    c = COD_BAIXO;
      else if (ev[BIT_DIREITA])  c = COD_DIREITA;
      return c;
   endfunction

   // Event code back to the one-hot jogada layout
   function automatic logic [5:0] decodifica(input logic [2:0] c);
      logic [5:0] d;
      d = '0;
      case (c)
         COD_CIMA:     d = 6'b100000;
         COD_BAIXO:    d = 6'b010000;
         COD_DIREITA:  d = 6'b001000;
         COD_ESQUERDA: d = 6'b000100;
         COD_TIRO:     d = 6'b000010;
         COD_ESPECIAL: d = 6'b000001;
         default:      d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/debounce_botao.sv
// debounce_botao -- 2-flop synchronizer plus level debouncer for one button.
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-low
//   botao_i   : raw asynchronous button level
//   nivel_o   : debounced level
//   subida_o  : one-cycle pulse, registered together with a 0->1 of nivel_o
module debounce_botao #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic botao_i,
   output logic nivel_o,
   output logic subida_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CARGA = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          nivel_q, nivel_d;
   logic          subida_q, subida_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Down-counter reloads whenever the synchronized input agrees with the
   // debounced level, so any bounce restarts the full window.
   always_comb begin
      nivel_d  = nivel_q;
      subida_d = 1'b0;
      cnt_d    = cnt_q;
      if (sync2_q == nivel_q) begin
         cnt_d = CARGA;
      end else if (cnt_q == '0) begin
         nivel_d  = sync2_q;
         subida_d = sync2_q;
         cnt_d    = CARGA;
      end else begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         nivel_q  <= 1'b0;
         subida_q <= 1'b0;
         cnt_q    <= CARGA;
      end else begin
         sync1_q  <= botao_i;
         sync2_q  <= sync1_q;
         nivel_q  <= nivel_d;
         subida_q <= subida_d;
         cnt_q    <= cnt_d;
      end
   end

   assign nivel_o  = nivel_q;
   assign subida_o = subida_q;

endmodule

// File: rtl/controle_jogada.sv
// controle_jogada -- turns six raw buttons into a queue of one-hot jogadas.
//   clock          : system clock, rising edge
//   reset          : asynchronous, active-low
//   botoes         : raw buttons {cima, baixo, direita, esquerda, tiro, especial}
//   habilita       : high = new events accepted
//   jogada_aceita  : consumer takes the head jogada this cycle
//   limpa_overflow : synchronous clear of the overflow flag
//   jogada         : one-hot head entry, zero when jogada_valida is low
//   jogada_valida  : FIFO holds at least one entry
//   overflow       : sticky, an event was dropped on a full FIFO
//   db_botoes      : debounced button levels
import astro_pkg::*;

module controle_jogada #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 8,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] botoes,
   input  logic       habilita,
   input  logic       jogada_aceita,
   input  logic       limpa_overflow,
   output logic [5:0] jogada,
   output logic       jogada_valida,
   output logic       overflow,
   output logic [5:0] db_botoes
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int PW = AW + 1;
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REP_CARGA = RW'(REPEAT_CYCLES - 1);

   logic [5:0]    db_nivel;
   logic [5:0]    subida;
   logic [5:0]    rep_evt;
   logic [5:0]    evento;
   logic [RW-1:0] rep_q [6];

   logic [2:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   logic          vazio, cheio;
   logic          pede_enq, enq, deq, descarta;

   for (genvar i = 0; i < 6; i++) begin : g_db
      debounce_botao #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce_botao (
         .clock    (clock),
         .reset    (reset),
         .botao_i  (botoes[i]),
         .nivel_o  (db_nivel[i]),
         .subida_o (subida[i])
      );
   end

   // Repeat timers: reloaded on the press pulse and while released, so the
   // first repeat lands REPEAT_CYCLES after the press event. They run
   // regardless of habilita.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 6; i++) rep_q[i] <= REP_CARGA;
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (!db_nivel[i] || subida[i] || rep_q[i] == '0)
               rep_q[i] <= REP_CARGA;
            else
               rep_q[i] <= rep_q[i] - RW'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 6; i++)
         rep_evt[i] = db_nivel[i] & ~subida[i] & (rep_q[i] == '0);
   end

   assign evento = subida | (rep_evt & MASCARA_REPETE);

   // Extra pointer bit separates full from empty when the indices match.
   assign vazio = (wr_ptr_q == rd_ptr_q);
   assign cheio = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   always_comb begin
      pede_enq   = habilita && (|evento);
      deq        = !vazio && jogada_aceita;
      // A dequeue in the same cycle frees the slot the new event needs.
      enq        = pede_enq && (!cheio || deq);
      descarta   = pede_enq && cheio && !deq;
      wr_ptr_d   = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
      overflow_d = overflow_q;
      if (descarta)            overflow_d = 1'b1;
      else if (limpa_overflow) overflow_d = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         if (enq) mem_q[wr_ptr_q[AW-1:0]] <= prioridade(evento);
      end
   end

   assign jogada_valida = !vazio;
   assign jogada        = vazio ? 6'b000000 : decodifica(mem_q[rd_ptr_q[AW-1:0]]);
   assign overflow      = overflow_q;
   assign db_botoes     = db_nivel;

endmodule

// File: tb/tb_controle_jogada.sv
module tb_controle_jogada;

   logic       clock;
   logic       reset;
   logic [5:0] botoes;
   logic       habilita;
   logic       jogada_aceita;
   logic       limpa_overflow;
   logic [5:0] jogada;
   logic       jogada_valida;
   logic       overflow;
   logic [5:0] db_botoes;

   int         n_vetores;
   int         n_erros;

   int         n_ev;
   int         ev_k [16];
   logic [5:0] ev_j [16];
   logic [5:0] db_or;

   controle_jogada #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_CYCLES   (8),
      .FIFO_DEPTH      (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .botoes         (botoes),
      .habilita       (habilita),
      .jogada_aceita  (jogada_aceita),
      .limpa_overflow (limpa_overflow),
      .jogada         (jogada),
      .jogada_valida  (jogada_valida),
      .overflow       (overflow),
      .db_botoes      (db_botoes)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vetores++;
      if (obs !== exp) begin
         n_erros++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive padrao right after an edge (edge 0), hold it for edges 1..hold,
   // optionally invert it every tog edges, then release. Every cycle in which
   // the consumer takes a jogada is logged with its edge number.
   task automatic aplica(input logic [5:0] padrao, input int hold, input int tog,
                         input int total);
      n_ev   = 0;
      db_or  = '0;
      botoes = padrao;
      for (int k = 1; k <= total; k++) begin
         tick();
         if (k >= hold)                        botoes = '0;
         else if (tog > 0 && (k % tog) == 0)   botoes = botoes ^ padrao;
         db_or = db_or | db_botoes;
         if (jogada_valida && jogada_aceita) begin
            if (n_ev < 16) begin
               ev_k[n_ev] = k;
               ev_j[n_ev] = jogada;
            end
            n_ev++;
         end
      end
   endtask

   initial begin
      logic [5:0] esperado [4];

      n_vetores      = 0;
      n_erros        = 0;
      reset          = 1'b0;
      botoes         = '0;
      habilita       = 1'b1;
      jogada_aceita  = 1'b0;
      limpa_overflow = 1'b0;

      repeat (3) tick();
      chk("rst_jogada",   {26'd0, jogada},     32'h0);
      chk("rst_valida",   {31'd0, jogada_valida}, 32'h0);
      chk("rst_overflow", {31'd0, overflow},   32'h0);
      chk("rst_db",       {26'd0, db_botoes},  32'h0);
      reset = 1'b1;
      tick();

      // Single shot press: one pulse, visible after the 7th edge
      jogada_aceita = 1'b1;
      aplica(6'b000010, 20, 0, 32);
      chk("tiro_n_ev",  n_ev,    1);
      chk("tiro_edge",  ev_k[0], 7);
      chk("tiro_val",   {26'd0, ev_j[0]}, 32'h02);

      // Bouncing special: never accepted
      aplica(6'b000001, 20, 2, 30);
      chk("bounce_n_ev", n_ev, 0);
      chk("bounce_db",   {26'd0, db_or}, 32'h0);

      // Held up: press plus three repeats, 8 cycles apart
      aplica(6'b100000, 30, 0, 45);
      chk("rep_n_ev", n_ev, 4);
      chk("rep_e0",   ev_k[0], 7);
      chk("rep_e1",   ev_k[1], 15);
      chk("rep_e2",   ev_k[2], 23);
      chk("rep_e3",   ev_k[3], 31);
      chk("rep_val",  {26'd0, ev_j[3]}, 32'h20);

      // Shot + special together: only special survives
      aplica(6'b000011, 15, 0, 25);
      chk("prio_n_ev", n_ev, 1);
      chk("prio_val",  {26'd0, ev_j[0]}, 32'h01);
      chk("prio_db",   {26'd0, db_or}, 32'h03);

      // habilita low: nothing queued, debouncer still tracks
      habilita = 1'b0;
      aplica(6'b000010, 10, 0, 20);
      chk("hab_n_ev", n_ev, 0);
      chk("hab_db",   {26'd0, db_or}, 32'h02);
      habilita = 1'b1;

      // Five presses with no consumer: four queued, fifth dropped
      jogada_aceita = 1'b0;
      aplica(6'b100000, 7, 0, 16);
      aplica(6'b010000, 7, 0, 16);
      aplica(6'b000010, 7, 0, 16);
      aplica(6'b000100, 7, 0, 16);
      chk("fila_ovf_antes", {31'd0, overflow}, 32'h0);
      aplica(6'b000001, 7, 0, 16);
      chk("fila_valida",  {31'd0, jogada_valida}, 32'h1);
      chk("fila_ovf",     {31'd0, overflow}, 32'h1);
      esperado[0] = 6'b100000;
      esperado[1] = 6'b010000;
      esperado[2] = 6'b000010;
      esperado[3] = 6'b000100;
      jogada_aceita = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fila_drena%0d", i), {26'd0, jogada}, {26'd0, esperado[i]});
         tick();
      end
      jogada_aceita = 1'b0;
      chk("fila_vazia",    {31'd0, jogada_valida}, 32'h0);
      chk("fila_vazia_j",  {26'd0, jogada}, 32'h0);
      chk("fila_ovf_fica", {31'd0, overflow}, 32'h1);
      limpa_overflow = 1'b1;
      tick();
      limpa_overflow = 1'b0;
      chk("fila_limpa", {31'd0, overflow}, 32'h0);

      // Full FIFO, new event on the same edge as a dequeue: no drop
      aplica(6'b100000, 7, 0, 16);
      aplica(6'b010000, 7, 0, 16);
      aplica(6'b001000, 7, 0, 16);
      aplica(6'b000100, 7, 0, 16);
      botoes = 6'b000010;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k == 6) jogada_aceita = 1'b1;
         if (k == 7) begin
            jogada_aceita = 1'b0;
            botoes        = '0;
         end
      end
      chk("simul_ovf",  {31'd0, overflow}, 32'h0);
      esperado[0] = 6'b010000;
      esperado[1] = 6'b001000;
      esperado[2] = 6'b000100;
      esperado[3] = 6'b000010;
      jogada_aceita = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("simul_drena%0d", i), {26'd0, jogada}, {26'd0, esperado[i]});
         tick();
      end
      chk("simul_vazia", {31'd0, jogada_valida}, 32'h0);
      jogada_aceita = 1'b0;

      // Reset mid-queue, button held across the release
      aplica(6'b100000, 7, 0, 16);
      aplica(6'b010000, 7, 0, 16);
      chk("rst2_valida_antes", {31'd0, jogada_valida}, 32'h1);
      botoes = 6'b000010;
      repeat (8) tick();
      #3;
      reset = 1'b0;
      #1;
      chk("rst2_valida", {31'd0, jogada_valida}, 32'h0);
      chk("rst2_jogada", {26'd0, jogada}, 32'h0);
      chk("rst2_ovf",    {31'd0, overflow}, 32'h0);
      chk("rst2_db",     {26'd0, db_botoes}, 32'h0);
      tick();
      reset         = 1'b1;
      jogada_aceita = 1'b1;
      aplica(6'b000010, 15, 0, 25);
      chk("rst2_n_ev", n_ev, 1);
      chk("rst2_edge", ev_k[0], 7);
      chk("rst2_val",  {26'd0, ev_j[0]}, 32'h02);

      $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
      $finish;
   end

endmodule

// File: doc/controle_jogada.md
CONTROLE_JOGADA -- requirements
Module: controle_jogada

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 8: hold time before a held movement button re-fires.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: pending-jogada buffer entries, power of two.
REQ-004 clock  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 botoes  input  6  raw asynchronous buttons: bit5 up, bit4 down, bit3 right, bit2 left, bit1 shot, bit0 special.
REQ-007 habilita  input  1  high = new button events accepted; low = events discarded.
REQ-008 jogada_aceita  input  1  consumer takes the current jogada this cycle.
REQ-009 limpa_overflow  input  1  synchronous clear of overflow flag.
REQ-010 jogada  output  6  one-hot jogada, same bit order as botoes; all-zero when jogada_valida low.
REQ-011 jogada_valida  output  1  jogada holds a pending event.
REQ-012 overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-013 db_botoes  output  6  debounced button levels.

Function
REQ-014 Each botoes bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounced level SHALL change only after synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-016 A 0->1 transition of a debounced level SHALL generate a press event.
REQ-017 Movement bits (5..2) held debounced-high SHALL generate a repeat event every REPEAT_CYCLES cycles after the press event; shot and special SHALL never repeat.
REQ-018 With several events in one cycle, only the highest-priority event SHALL be enqueued (special > shot > up > down > right > left); others are discarded.
REQ-019 Events with habilita low SHALL be discarded; debounce and repeat timers SHALL keep running.
REQ-020 Events SHALL be stored as 3-bit codes in a first-word-fall-through FIFO of FIFO_DEPTH entries; jogada is the decoded head entry.
REQ-021 Latency: with empty FIFO, jogada_valida SHALL rise on the (DEBOUNCE_CYCLES+3)th rising edge after botoes goes and stays high.
REQ-022 Dequeue SHALL occur on a cycle with jogada_valida and jogada_aceita both high; jogada_aceita with FIFO empty SHALL be ignored.
REQ-023 Event arriving with FIFO full and no dequeue that cycle SHALL be dropped and overflow set; with a simultaneous dequeue it SHALL be enqueued, no overflow.
REQ-024 limpa_overflow SHALL clear overflow unless a new drop occurs the same cycle (set wins).
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-026 Reset low SHALL immediately clear synchronizers, debounced levels, counters, FIFO, overflow; outputs jogada=0, jogada_valida=0, overflow=0, db_botoes=0.
REQ-027 A button held across reset release SHALL yield one press event after the normal REQ-021 latency.

Structure
REQ-028 Bit indices, event code values and priority order SHALL live in shared package astro_pkg, alongside astro_genius constants.
REQ-029 Per-bit synchronizer+debouncer SHALL be sub-module debounce_botao, instantiated 6 times; FIFO and priority logic stay in controle_jogada.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, FIFO_DEPTH=4)
REQ-030 botoes=000010 held 20 cycles, jogada_aceita=1 -> exactly one jogada=000010 pulse, valid on 7th edge after press.
REQ-031 botoes bit0 toggled every 2 cycles for 20 cycles, then 0 -> no event, db_botoes stays 000000.
REQ-032 botoes=100000 held 30 cycles, jogada_aceita=1 -> jogada=100000 at press+7, then every 8 cycles (4 events total).
REQ-033 botoes=000011 pressed together -> only 000001 enqueued; 000010 discarded.
REQ-034 jogada_aceita=0, five distinct presses -> 4 queued in order, overflow=1; draining yields the first four; limpa_overflow -> overflow=0.
REQ-035 Reset low mid-queue with 2 entries -> jogada_valida=0, overflow=0 asynchronously; held button re-fires once after release.
